multiport_register_file: RTL

Parametrised next-generation CPU register file: configurable data width, address width and read-port count, with one write port, registered read outputs, write-to-read bypass, a configurable hardwired-zero register, and a sequential bulk-clear engine. It sits in the decode/writeback boundary of the single-cycle datapath and replaces the fixed 32x64, two-read-port file.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_read_port.sv | 43 ++++
 rtl/multiport_register_file.sv | 99 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and default widths for the multiport register file.
package rf_pkg;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

    localparam int RF_DATA_W = 64;
    localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: zero forcing, write bypass, output flop.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter bit ZERO_EN  = 1'b1,
    parameter int ZERO_IDX = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              byp_en,
    input  logic [ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0] busw,
    output logic [DATA_W-1:0] bus
);

    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_IDX);

    logic              is_zero;
    logic              hit;
    logic [DATA_W-1:0] d_n;

    assign is_zero = ZERO_EN && (ra == ZADDR);
    assign hit     = byp_en && (rw == ra) && !is_zero;

    always_comb begin
        d_n = arr_data;
        unique case (1'b1)
            is_zero: d_n = '0;
            hit:     d_n = busw;
            default: d_n = arr_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus <= '0;
        else        bus <= d_n;
    end

endmodule

// File: rtl/multiport_register_file.sv
// Register file: one write port, N_RD registered read ports with
// bypass, optional hardwired-zero register, sequential bulk clear.
module multiport_register_file
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int N_RD     = 2,
    parameter bit ZERO_EN  = 1'b1,
    parameter int ZERO_IDX = 31
) (
    input  logic                     Clk,
    input  logic                     ResetL,
    input  logic [N_RD*ADDR_W-1:0]   RA,
    output logic [N_RD*DATA_W-1:0]   Bus,
    input  logic [ADDR_W-1:0]        RW,
    input  logic [DATA_W-1:0]        BusW,
    input  logic                     RegWr,
    input  logic                     ClrReq,
    output logic                     ClrBusy,
    output logic                     ClrDone
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_IDX);

    logic [DATA_W-1:0] mem [DEPTH];
    rf_state_t         state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic              idle;
    logic              wr_ok;

    assign idle  = (state == RF_IDLE);
    assign wr_ok = idle && RegWr && !(ZERO_EN && (RW == ZADDR));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            RF_IDLE: begin
                if (ClrReq) begin
                    state_n = RF_CLEAR;
                    cnt_n   = '0;
                end
            end
            RF_CLEAR: begin
                cnt_n = cnt + 1'b1;
                if (cnt == '1) state_n = RF_IDLE;
            end
            default: state_n = RF_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            state <= RF_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Clear and write are exclusive: writes are only taken in IDLE.
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == RF_CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[RW] <= BusW;
        end
    end

    assign ClrBusy = (state == RF_CLEAR);
    assign ClrDone = (state == RF_CLEAR) && (cnt == '1);

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;
        assign ra_k = RA[k*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_EN  (ZERO_EN),
            .ZERO_IDX (ZERO_IDX)
        ) u_port (
            .clk      (Clk),
            .rst_n    (ResetL),
            .ra       (ra_k),
            .arr_data (mem[ra_k]),
            .byp_en   (idle && RegWr),
            .rw       (RW),
            .busw     (BusW),
            .bus      (Bus[k*DATA_W +: DATA_W])
        );
    end

endmodule
